row_window_ctrl: RTL and testbench
==================================

// Module: row_window_ctrl
// PURPOSE
//  Pointer/occupancy controller for the circular row buffer feeding the row-length counter stage.
//  Accepts one element per cycle on the write side and advances a write pointer.
//  Serves variable-length row windows to the downstream consumer as start/end address pairs.
//  Emits up_enable/down_enable strobes and the window addresses that drive the length counter.
// PARAMETERS
//  POINTER_SIZE  4  buffer address width; DEPTH = 2**POINTER_SIZE entries
//  LEN_WIDTH     5  width of req_len and of internal occupancy count (>= POINTER_SIZE+1)
// PORTS
//  clk             in   1             rising-edge clock
//  rst             in   1             async active-high reset
//  in_valid        in   1             producer has an element
//  in_ready        out  1             buffer can accept (count < DEPTH-1)
//  wr_addr         out  POINTER_SIZE  buffer write address for current accept
//  req_valid       in   1             consumer requests a window
//  req_len         in   LEN_WIDTH     requested window length
//  req_ready       out  1             high only in IDLE
//  win_valid       out  1             window addresses valid (WINDOW state)
//  win_done        in   1             consumer finished with window
//  start_row_addr  out  POINTER_SIZE  first address of window
//  end_row_addr    out  POINTER_SIZE  last address of window (inclusive, wraps)
//  up_enable       out  1             = in_valid & in_ready (combinational)
//  down_enable     out  1             one-cycle release pulse (RELEASE state)
//  count           out  LEN_WIDTH     occupied entries
// BEHAVIOUR
//  Reset: state=IDLE; wr_ptr, rd_ptr, count, len_q = 0; win_valid, down_enable = 0; req_ready = 1.
//  Write: on up_enable, buffer[wr_ptr] written externally, wr_ptr <= wr_ptr+1 mod DEPTH.
//  Length rule: legal len is 1..DEPTH-1 (end-start+1 mod DEPTH must equal len downstream).
//    req_len=0 -> request ignored, stay IDLE, req_ready stays 1.
//    req_len >= DEPTH -> saturated to DEPTH-1 when latched.
//  FSM:
//    IDLE:      req_ready=1; req_valid & legal len -> latch len_q, go FILL.
//    FILL:      wait until count >= len_q (checked on registered count) -> WINDOW.
//    WINDOW:    win_valid=1; start=rd_ptr, end=rd_ptr+len_q-1 mod DEPTH, held stable;
//               win_done sampled only here -> RELEASE.
//    RELEASE:   down_enable=1 for exactly one cycle; rd_ptr <= rd_ptr+len_q mod DEPTH;
//               start/end still hold released window this cycle; -> IDLE.
//  Addresses: start/end outputs registered from rd_ptr/len_q, valid from FILL->WINDOW edge on.
//  count next = count + up_enable - (down_enable ? len_q : 0); write and release same cycle allowed.
//  Full: in_ready=0 when count = DEPTH-1 (one slot kept free so wr_ptr never laps rd_ptr).
//  Empty: count=0 with pending request -> remain FILL indefinitely; no timeout.
//  Writes proceed in every state, including WINDOW (window entries never overwritten: full rule).
//  win_done outside WINDOW ignored; req_valid outside IDLE ignored (req_ready=0).
//  Reset mid-window: window dropped, pointers/count cleared, no down_enable issued.
//  Latency: request->win_valid min 2 cycles (IDLE->FILL->WINDOW); win_done->down_enable 1 cycle.
// TESTING
//  1 Reset then 5 writes, req_len=3 -> win_valid after 2 cyc, start=0 end=2; win_done -> one down_enable, count 5->2.
//  2 Wrap: rd_ptr=14, 4 valid, req_len=4 -> start=14 end=1; after release rd_ptr=2.
//  3 Full: in_valid held high from empty -> in_ready drops at count=15, wr_ptr=15, no further writes.
//  4 Simultaneous write in RELEASE with len_q=3, count=6 -> count=4 next cycle.
//  5 req_len=0 -> no state change; req_len=20 -> len_q=15; req before data -> stays FILL until count>=len.
//  6 rst asserted during WINDOW -> all outputs to reset values asynchronously, no down_enable pulse.

Source files
------------

// File: rtl/row_window_ctrl.sv
// Pointer/occupancy controller for the circular row buffer ahead of the
// row-length counter. The producer side writes one element per accepted
// cycle. The consumer side asks for a window of N rows and gets an
// inclusive start/end address pair. When the consumer finishes, the
// window is released with a one-cycle down_enable pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | ready for a request; req_ready high
// S_FILL    | length latched; waiting for occupancy to reach it
// S_WINDOW  | window addresses valid; waiting for win_done
// S_RELEASE | one-cycle release: down_enable high, rd_ptr advances
module row_window_ctrl #(
    parameter int POINTER_SIZE = 4,
    parameter int LEN_WIDTH    = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [POINTER_SIZE-1:0] wr_addr_o,
    input  logic                    req_valid_i,
    input  logic [LEN_WIDTH-1:0]    req_len_i,
    output logic                    req_ready_o,
    output logic                    win_valid_o,
    input  logic                    win_done_i,
    output logic [POINTER_SIZE-1:0] start_row_addr_o,
    output logic [POINTER_SIZE-1:0] end_row_addr_o,
    output logic                    up_enable_o,
    output logic                    down_enable_o,
    output logic [LEN_WIDTH-1:0]    count_o
);

    localparam int                   DEPTH   = 2 ** POINTER_SIZE;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_WINDOW  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                  state_q;
    logic [POINTER_SIZE-1:0] wr_ptr_q;
    logic [POINTER_SIZE-1:0] wr_ptr_d;
    logic [POINTER_SIZE-1:0] rd_ptr_q;
    logic [POINTER_SIZE-1:0] start_q;
    logic [POINTER_SIZE-1:0] end_q;
    logic [LEN_WIDTH-1:0]    count_q;
    logic [LEN_WIDTH-1:0]    count_d;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    req_len_sat;
    logic [POINTER_SIZE-1:0] len_ptr;
    logic                    win_valid_q;
    logic                    down_enable_q;
    logic                    req_ready_q;
    logic                    in_ready;
    logic                    up_enable;

    // One slot is always kept free, so the write pointer can never lap
    // the oldest entry of an outstanding window.
    assign in_ready  = (count_q < MAX_LEN);
    assign up_enable = in_valid_i & in_ready;

    // Lengths of DEPTH or more cannot be expressed as a start/end pair,
    // so they are clamped to the largest window the buffer can hold.
    assign req_len_sat = (req_len_i >= LEN_WIDTH'(DEPTH)) ? MAX_LEN : req_len_i;

    // len_q never exceeds DEPTH-1, so dropping the top bit is lossless.
    assign len_ptr = len_q[POINTER_SIZE-1:0];

    // Next occupancy: a write and a release may land in the same cycle.
    always_comb begin
        count_d  = count_q + LEN_WIDTH'(up_enable)
                   - (down_enable_q ? len_q : '0);
        wr_ptr_d = up_enable ? (wr_ptr_q + POINTER_SIZE'(1)) : wr_ptr_q;
    end

    // Write pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Window sequencing FSM with registered handshake and address outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            rd_ptr_q      <= '0;
            start_q       <= '0;
            end_q         <= '0;
            win_valid_q   <= 1'b0;
            down_enable_q <= 1'b0;
            req_ready_q   <= 1'b1;
        end else begin
            down_enable_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A zero-length request is silently dropped.
                    if (req_valid_i && (req_len_i != '0)) begin
                        len_q       <= req_len_sat;
                        req_ready_q <= 1'b0;
                        state_q     <= S_FILL;
                    end
                end
                S_FILL: begin
                    // Occupancy only grows while filling, so once the
                    // threshold is met it stays met for the whole window.
                    if (count_q >= len_q) begin
                        start_q     <= rd_ptr_q;
                        end_q       <= rd_ptr_q + len_ptr - POINTER_SIZE'(1);
                        win_valid_q <= 1'b1;
                        state_q     <= S_WINDOW;
                    end
                end
                S_WINDOW: begin
                    if (win_done_i) begin
                        win_valid_q   <= 1'b0;
                        down_enable_q <= 1'b1;
                        state_q       <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // start/end keep the released window until the next
                    // FILL->WINDOW edge.
                    rd_ptr_q    <= rd_ptr_q + len_ptr;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o       = in_ready;
    assign up_enable_o      = up_enable;
    assign wr_addr_o        = wr_ptr_q;
    assign req_ready_o      = req_ready_q;
    assign win_valid_o      = win_valid_q;
    assign down_enable_o    = down_enable_q;
    assign start_row_addr_o = start_q;
    assign end_row_addr_o   = end_q;
    assign count_o          = count_q;

endmodule

// File: tb/tb_row_window_ctrl.sv
// Bench for row_window_ctrl. The reference model treats the buffer as a
// queue of written addresses: a write appends its address, and a release
// drops the oldest len entries. A window spans from the head of the queue
// to entry len-1.
module tb_row_window_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] wr_addr;
    logic       req_valid;
    logic [4:0] req_len;
    logic       req_ready;
    logic       win_valid;
    logic       win_done;
    logic [3:0] start_row_addr;
    logic [3:0] end_row_addr;
    logic       up_enable;
    logic       down_enable;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_q[$];
    int m_wr;
    int m_mode;   // 0 waiting for request, 1 waiting for data, 2 window open, 3 releasing
    int m_len;
    int m_start;
    int m_end;

    row_window_ctrl #(.POINTER_SIZE(4), .LEN_WIDTH(5)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .wr_addr_o        (wr_addr),
        .req_valid_i      (req_valid),
        .req_len_i        (req_len),
        .req_ready_o      (req_ready),
        .win_valid_o      (win_valid),
        .win_done_i       (win_done),
        .start_row_addr_o (start_row_addr),
        .end_row_addr_o   (end_row_addr),
        .up_enable_o      (up_enable),
        .down_enable_o    (down_enable),
        .count_o          (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wr    = 0;
        m_mode  = 0;
        m_len   = 0;
        m_start = 0;
        m_end   = 0;
    endtask

    task automatic model_step(input bit iv, input bit rv, input int rl, input bit wd);
        int n;
        int rlm;
        int nxt;
        bit up;
        n   = m_q.size();
        rlm = rl & 31;
        up  = iv && (n < 15);
        nxt = m_mode;
        case (m_mode)
            0: if (rv && rlm != 0) begin
                m_len = (rlm > 15) ? 15 : rlm;
                nxt   = 1;
            end
            1: if (n >= m_len) begin
                m_start = m_q[0];
                m_end   = m_q[m_len-1];
                nxt     = 2;
            end
            2: if (wd) nxt = 3;
            default: begin
                repeat (m_len) void'(m_q.pop_front());
                nxt = 0;
            end
        endcase
        if (up) begin
            m_q.push_back(m_wr);
            m_wr = (m_wr + 1) % 16;
        end
        m_mode = nxt;
    endtask

    task automatic check_regs();
        chk("count", count, m_q.size());
        chk("req_ready", req_ready, (m_mode == 0));
        chk("win_valid", win_valid, (m_mode == 2));
        chk("down_enable", down_enable, (m_mode == 3));
        chk("start", start_row_addr, m_start);
        chk("end", end_row_addr, m_end);
    endtask

    // One clock: drive at negedge, check combinational outputs, step model at posedge.
    task automatic cyc(input bit iv, input bit rv, input int rl, input bit wd);
        int rl5;
        rl5       = rl & 31;
        in_valid  = iv;
        req_valid = rv;
        req_len   = rl5[4:0];
        win_done  = wd;
        #1;
        chk("in_ready", in_ready, (m_q.size() < 15));
        chk("up_enable", up_enable, (iv && m_q.size() < 15));
        chk("wr_addr", wr_addr, m_wr);
        @(posedge clk);
        model_step(iv, rv, rl, wd);
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        req_valid = 1'b0;
        req_len   = '0;
        win_done  = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic writes(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        req_valid = 1'b0;
        req_len   = '0;
        win_done  = 1'b0;
        model_reset();
        #1;
        check_regs();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_addr", wr_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // basic window: 5 rows in, window of 3
        writes(5);
        cyc(0, 1, 3, 0);
        chk("t1_fill_win_valid", win_valid, 0);
        idle(1);
        chk("t1_win_valid", win_valid, 1);
        chk("t1_start", start_row_addr, 0);
        chk("t1_end", end_row_addr, 2);
        cyc(0, 0, 0, 1);
        chk("t1_down_pulse", down_enable, 1);
        idle(1);
        chk("t1_down_gone", down_enable, 0);
        chk("t1_count", count, 2);

        // wrap: move rd_ptr to 14, then a window of 4 crosses the end
        do_reset();
        writes(14);
        cyc(0, 1, 14, 0);
        idle(1);
        cyc(0, 0, 0, 1);
        idle(1);
        chk("t2_empty", count, 0);
        writes(4);
        cyc(0, 1, 4, 0);
        idle(1);
        chk("t2_start", start_row_addr, 14);
        chk("t2_end", end_row_addr, 1);
        cyc(0, 0, 0, 1);
        idle(1);
        writes(1);
        cyc(0, 1, 1, 0);
        idle(1);
        chk("t2_next_start", start_row_addr, 2);
        chk("t2_next_end", end_row_addr, 2);
        cyc(0, 0, 0, 1);
        idle(1);

        // full: in_valid held from empty
        do_reset();
        writes(17);
        chk("t3_count", count, 15);
        chk("t3_wr_addr", wr_addr, 15);
        in_valid = 1'b1;
        #1;
        chk("t3_in_ready", in_ready, 0);
        chk("t3_up_enable", up_enable, 0);
        @(negedge clk);

        // oversize request is clamped to 15
        cyc(0, 1, 20, 0);
        idle(1);
        chk("t5_sat_start", start_row_addr, 0);
        chk("t5_sat_end", end_row_addr, 14);
        cyc(0, 0, 0, 1);
        idle(1);
        chk("t5_sat_count", count, 0);

        // zero-length request is ignored
        cyc(0, 1, 0, 0);
        chk("t5_zero_ready", req_ready, 1);
        idle(2);
        chk("t5_zero_win", win_valid, 0);

        // request before data: parked in FILL until 2 rows present
        cyc(0, 1, 2, 0);
        idle(4);
        chk("t5_wait_win", win_valid, 0);
        chk("t5_wait_ready", req_ready, 0);
        writes(2);
        idle(1);
        chk("t5_late_win", win_valid, 1);
        chk("t5_late_start", start_row_addr, 15);
        chk("t5_late_end", end_row_addr, 0);
        cyc(0, 0, 0, 1);
        idle(1);

        // write coincident with release: 6 + 1 - 3 = 4
        do_reset();
        writes(6);
        cyc(0, 1, 3, 0);
        idle(1);
        cyc(0, 0, 0, 1);
        chk("t4_pre_count", count, 6);
        cyc(1, 0, 0, 0);
        chk("t4_count", count, 4);

        // async reset while a window is open
        do_reset();
        writes(4);
        cyc(0, 1, 2, 0);
        idle(1);
        chk("t6_win_open", win_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_win_valid", win_valid, 0);
        chk("t6_count", count, 0);
        chk("t6_req_ready", req_ready, 1);
        chk("t6_down", down_enable, 0);
        chk("t6_wr_addr", wr_addr, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 1);
        chk("t6_no_release", down_enable, 0);
        idle(2);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset();
            cyc($urandom_range(0, 99) < 55,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 20),
                $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
